// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  // Address width for a given depth; never narrower than one bit.
  function automatic int unsigned rf_addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Bulk-clear sequencer: sweeps every entry once, one per cycle, after a request in IDLE.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr_req,
  output logic          o_clr_busy,
  output logic          o_clr_en_c,
  output logic [AW-1:0] o_clr_addr_c
);

  rf_state_e     r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic          r_busy, w_busy_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RF_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Requests arriving mid-sweep are ignored; the sweep always runs DEPTH cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    if (r_state == RF_IDLE) begin
      if (i_clr_req) begin
        w_state_nxt = RF_CLEAR;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b1;
      end
    end else begin
      if (32'(r_cnt) == DEPTH - 1) begin
        w_state_nxt = RF_IDLE;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end else begin
        w_cnt_nxt = r_cnt + AW'(1);
      end
    end
  end

  assign o_clr_busy   = r_busy;
  assign o_clr_en_c   = (r_state == RF_CLEAR);
  assign o_clr_addr_c = r_cnt;

endmodule

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with valid flags, write-first
// registered reads and a sequential bulk clear.
module regfile_param
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = rf_addr_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             CLRN,
  input  logic             WR,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] LD_DATA,
  input  logic [AW-1:0]    RP,
  input  logic [AW-1:0]    RQ,
  output logic [WIDTH-1:0] DATAP,
  output logic [WIDTH-1:0] DATAQ,
  output logic             VALIDP,
  output logic             VALIDQ,
  input  logic             CLR_REQ,
  output logic             CLR_BUSY,
  output logic             WR_DROP
);

  logic [WIDTH-1:0] r_mem   [DEPTH];
  logic             r_valid [DEPTH];
  logic [WIDTH-1:0] r_datap, r_dataq;
  logic             r_validp, r_validq, r_wr_drop;

  logic             w_clr_en;
  logic [AW-1:0]    w_clr_addr;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_datap_nxt, w_dataq_nxt;
  logic             w_validp_nxt, w_validq_nxt;

  regfile_clr_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_fsm (
    .i_clk        (CLK),
    .i_rst_n      (CLRN),
    .i_clr_req    (CLR_REQ),
    .o_clr_busy   (CLR_BUSY),
    .o_clr_en_c   (w_clr_en),
    .o_clr_addr_c (w_clr_addr)
  );

  // A clear request or an active sweep blocks the write port.
  assign w_wr_ok = WR && !w_clr_en && !CLR_REQ && (32'(WA) < DEPTH);

  // Next read values: out-of-range -> 0, clear-first, then write-first, then storage.
  always_comb begin
    w_datap_nxt  = '0;
    w_validp_nxt = 1'b0;
    w_dataq_nxt  = '0;
    w_validq_nxt = 1'b0;
    if (32'(RP) < DEPTH && !(w_clr_en && w_clr_addr == RP)) begin
      if (w_wr_ok && WA == RP) begin
        w_datap_nxt  = LD_DATA;
        w_validp_nxt = 1'b1;
      end else begin
        w_datap_nxt  = r_mem[RP];
        w_validp_nxt = r_valid[RP];
      end
    end
    if (32'(RQ) < DEPTH && !(w_clr_en && w_clr_addr == RQ)) begin
      if (w_wr_ok && WA == RQ) begin
        w_dataq_nxt  = LD_DATA;
        w_validq_nxt = 1'b1;
      end else begin
        w_dataq_nxt  = r_mem[RQ];
        w_validq_nxt = r_valid[RQ];
      end
    end
  end

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i]   <= '0;
        r_valid[i] <= 1'b0;
      end
    end else if (w_clr_en) begin
      r_mem[w_clr_addr]   <= '0;
      r_valid[w_clr_addr] <= 1'b0;
    end else if (w_wr_ok) begin
      r_mem[WA]   <= LD_DATA;
      r_valid[WA] <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      r_datap   <= '0;
      r_dataq   <= '0;
      r_validp  <= 1'b0;
      r_validq  <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_datap   <= w_datap_nxt;
      r_dataq   <= w_dataq_nxt;
      r_validp  <= w_validp_nxt;
      r_validq  <= w_validq_nxt;
      r_wr_drop <= WR && !w_wr_ok;
    end
  end

  assign DATAP   = r_datap;
  assign DATAQ   = r_dataq;
  assign VALIDP  = r_validp;
  assign VALIDQ  = r_validq;
  assign WR_DROP = r_wr_drop;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: an 8x4 instance and a 6x16 instance against array models.
module tb_regfile_param;

  logic CLK = 1'b0;
  logic CLRN;
  always #5 CLK = ~CLK;

  // 8 x 4 instance
  logic       wr8, clr8, dp8_v, dq8_v, busy8, drop8;
  logic [2:0] wa8, rp8, rq8;
  logic [3:0] ld8, dp8, dq8;
  // 6 x 16 instance
  logic        wr6, clr6, dp6_v, dq6_v, busy6, drop6;
  logic [2:0]  wa6, rp6, rq6;
  logic [15:0] ld6, dp6, dq6;

  regfile_param #(.WIDTH(4), .DEPTH(8)) dut8 (
    .CLK(CLK), .CLRN(CLRN), .WR(wr8), .WA(wa8), .LD_DATA(ld8),
    .RP(rp8), .RQ(rq8), .DATAP(dp8), .DATAQ(dq8), .VALIDP(dp8_v), .VALIDQ(dq8_v),
    .CLR_REQ(clr8), .CLR_BUSY(busy8), .WR_DROP(drop8)
  );

  regfile_param #(.WIDTH(16), .DEPTH(6)) dut6 (
    .CLK(CLK), .CLRN(CLRN), .WR(wr6), .WA(wa6), .LD_DATA(ld6),
    .RP(rp6), .RQ(rq6), .DATAP(dp6), .DATAQ(dq6), .VALIDP(dp6_v), .VALIDQ(dq6_v),
    .CLR_REQ(clr6), .CLR_BUSY(busy6), .WR_DROP(drop6)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0]  m8 [8];
  logic        v8 [8];
  logic [15:0] m6 [6];
  logic        v6 [6];

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic model_zero;
    for (int i = 0; i < 8; i++) begin m8[i] = '0; v8[i] = 1'b0; end
    for (int i = 0; i < 6; i++) begin m6[i] = '0; v6[i] = 1'b0; end
  endtask

  task automatic read_all_zero8(input string tag);
    for (int a = 0; a < 8; a++) begin
      rp8 = 3'(a);
      rq8 = 3'(7 - a);
      step;
      n_checks++;
      if ({dp8_v, dp8, dq8_v, dq8} !== 10'd0) begin
        n_errors++;
        $display("FAIL %s addr %0d got P=%0b/%0h Q=%0b/%0h exp 0/0", tag, a, dp8_v, dp8, dq8_v, dq8);
      end
    end
  endtask

  task automatic test_reset;
    wr8 = 0; clr8 = 0; wa8 = 0; ld8 = 0; rp8 = 0; rq8 = 0;
    wr6 = 0; clr6 = 0; wa6 = 0; ld6 = 0; rp6 = 0; rq6 = 0;
    CLRN = 1'b0;
    #13;
    n_checks++;
    if ({dp8_v, dp8, dq8_v, dq8, busy8, drop8} !== 12'd0) begin
      n_errors++;
      $display("FAIL reset_out8 got %0h exp 0", {dp8_v, dp8, dq8_v, dq8, busy8, drop8});
    end
    n_checks++;
    if ({dp6_v, dp6, dq6_v, dq6, busy6, drop6} !== 36'd0) begin
      n_errors++;
      $display("FAIL reset_out6 got %0h exp 0", {dp6_v, dp6, dq6_v, dq6, busy6, drop6});
    end
    @(negedge CLK);
    CLRN = 1'b1;
    model_zero();
    read_all_zero8("reset_read");
  endtask

  task automatic test_write_read;
    wr8 = 1; wa8 = 3'd5; ld8 = 4'hA; rp8 = 3'd2; rq8 = 3'd2;
    step;
    m8[5] = 4'hA; v8[5] = 1'b1;
    n_checks++;
    if (drop8 !== 1'b0) begin n_errors++; $display("FAIL wr_nodrop got %0b exp 0", drop8); end
    wr8 = 0; rp8 = 3'd5; rq8 = 3'd5;
    step;
    n_checks++;
    if ({dp8_v, dp8, dq8_v, dq8} !== {1'b1, 4'hA, 1'b1, 4'hA}) begin
      n_errors++;
      $display("FAIL read_a5 got P=%0b/%0h Q=%0b/%0h exp 1/a", dp8_v, dp8, dq8_v, dq8);
    end
    rp8 = 3'd2; rq8 = 3'd2;
    step;
    n_checks++;
    if ({dp8_v, dp8, dq8_v, dq8} !== 10'd0) begin
      n_errors++;
      $display("FAIL read_unwritten got P=%0b/%0h Q=%0b/%0h exp 0/0", dp8_v, dp8, dq8_v, dq8);
    end
  endtask

  task automatic test_write_first;
    wr8 = 1; wa8 = 3'd3; ld8 = 4'h6; rp8 = 3'd3; rq8 = 3'd3;
    step;
    m8[3] = 4'h6; v8[3] = 1'b1;
    n_checks++;
    if ({dp8_v, dp8, dq8_v, dq8} !== {1'b1, 4'h6, 1'b1, 4'h6}) begin
      n_errors++;
      $display("FAIL write_first got P=%0b/%0h Q=%0b/%0h exp 1/6", dp8_v, dp8, dq8_v, dq8);
    end
    wr8 = 0; ld8 = 4'hF;
    step;
    n_checks++;
    if ({dp8_v, dp8} !== {1'b1, 4'h6}) begin
      n_errors++;
      $display("FAIL wr_disabled got %0b/%0h exp 1/6", dp8_v, dp8);
    end
  endtask

  task automatic test_random8;
    logic [3:0] ep, eq;
    logic       evp, evq;
    for (int i = 0; i < 200; i++) begin
      wr8 = 1'($urandom);
      wa8 = 3'($urandom);
      ld8 = 4'($urandom);
      rp8 = 3'($urandom);
      rq8 = 3'($urandom);
      ep = m8[rp8]; evp = v8[rp8];
      eq = m8[rq8]; evq = v8[rq8];
      if (wr8 && wa8 == rp8) begin ep = ld8; evp = 1'b1; end
      if (wr8 && wa8 == rq8) begin eq = ld8; evq = 1'b1; end
      if (wr8) begin m8[wa8] = ld8; v8[wa8] = 1'b1; end
      step;
      n_checks++;
      if ({dp8_v, dp8} !== {evp, ep}) begin
        n_errors++;
        $display("FAIL rand8_p it %0d got %0b/%0h exp %0b/%0h", i, dp8_v, dp8, evp, ep);
      end
      n_checks++;
      if ({dq8_v, dq8} !== {evq, eq}) begin
        n_errors++;
        $display("FAIL rand8_q it %0d got %0b/%0h exp %0b/%0h", i, dq8_v, dq8, evq, eq);
      end
      n_checks++;
      if (drop8 !== 1'b0) begin
        n_errors++;
        $display("FAIL rand8_drop it %0d got %0b exp 0", i, drop8);
      end
    end
    wr8 = 0;
  endtask

  task automatic test_clear;
    int busy_cnt;
    for (int a = 0; a < 8; a++) begin
      wr8 = 1; wa8 = 3'(a); ld8 = 4'($urandom_range(1, 15));
      m8[a] = ld8; v8[a] = 1'b1;
      step;
    end
    wr8 = 0; clr8 = 1; rp8 = 0; rq8 = 3'd1;
    step;
    clr8 = 0;
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!busy8) break;
      busy_cnt++;
      if (k >= 1 && k <= 7) begin
        n_checks++;
        if ({dp8_v, dp8} !== 5'd0) begin
          n_errors++;
          $display("FAIL clear_first k %0d got %0b/%0h exp 0/0", k, dp8_v, dp8);
        end
        n_checks++;
        if ({dq8_v, dq8} !== {1'b1, m8[k]}) begin
          n_errors++;
          $display("FAIL clear_keep k %0d got %0b/%0h exp 1/%0h", k, dq8_v, dq8, m8[k]);
        end
      end
      if (k == 3) begin
        n_checks++;
        if (drop8 !== 1'b1) begin n_errors++; $display("FAIL clear_wr_drop got %0b exp 1", drop8); end
      end
      rp8 = 3'(k);
      rq8 = 3'((k + 1) % 8);
      wr8 = (k == 2); wa8 = 3'd0; ld8 = 4'hF;
      step;
    end
    wr8 = 0;
    n_checks++;
    if (busy_cnt != 8) begin n_errors++; $display("FAIL clear_busy_len got %0d exp 8", busy_cnt); end
    model_zero();
    read_all_zero8("after_clear");
  endtask

  task automatic test_collision;
    int busy_cnt;
    wr8 = 1; wa8 = 3'd1; ld8 = 4'h3;
    step;
    clr8 = 1; wr8 = 1; wa8 = 3'd1; ld8 = 4'h9;
    step;
    clr8 = 0; wr8 = 0;
    n_checks++;
    if ({drop8, busy8} !== 2'b11) begin
      n_errors++;
      $display("FAIL collide_drop got drop=%0b busy=%0b exp 1/1", drop8, busy8);
    end
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!busy8) break;
      busy_cnt++;
      clr8 = (k == 3);
      step;
    end
    clr8 = 0;
    n_checks++;
    if (busy_cnt != 8) begin n_errors++; $display("FAIL reclr_busy_len got %0d exp 8", busy_cnt); end
    rp8 = 3'd1; rq8 = 3'd1;
    step;
    n_checks++;
    if ({dp8_v, dp8, dq8_v, dq8} !== 10'd0) begin
      n_errors++;
      $display("FAIL collide_entry1 got P=%0b/%0h Q=%0b/%0h exp 0/0", dp8_v, dp8, dq8_v, dq8);
    end
  endtask

  task automatic test_reset_mid_sweep;
    wr8 = 1; wa8 = 3'd5; ld8 = 4'hC; rp8 = 3'd5; rq8 = 3'd5;
    step;
    wr8 = 0; clr8 = 1;
    step;
    clr8 = 0;
    step;
    step;
    step;
    n_checks++;
    if ({busy8, dp8_v, dp8} !== {1'b1, 1'b1, 4'hC}) begin
      n_errors++;
      $display("FAIL pre_reset got busy=%0b P=%0b/%0h exp 1 1/c", busy8, dp8_v, dp8);
    end
    #2 CLRN = 1'b0;
    #1;
    n_checks++;
    if ({busy8, dp8_v, dp8, dq8_v, dq8} !== 11'd0) begin
      n_errors++;
      $display("FAIL reset_async got busy=%0b P=%0b/%0h Q=%0b/%0h exp 0", busy8, dp8_v, dp8, dq8_v, dq8);
    end
    @(negedge CLK);
    CLRN = 1'b1;
    model_zero();
    step;
    n_checks++;
    if (busy8 !== 1'b0) begin n_errors++; $display("FAIL post_reset_busy got %0b exp 0", busy8); end
    read_all_zero8("mid_sweep_reset");
  endtask

  task automatic test_depth6;
    logic [15:0] ep, eq;
    logic        evp, evq, ok, edrop;
    wr6 = 1; wa6 = 3'd6; ld6 = 16'h1234; rp6 = 0; rq6 = 0;
    step;
    n_checks++;
    if (drop6 !== 1'b1) begin n_errors++; $display("FAIL d6_oob_drop got %0b exp 1", drop6); end
    wa6 = 3'd5; ld6 = 16'hBEEF;
    step;
    m6[5] = 16'hBEEF; v6[5] = 1'b1;
    n_checks++;
    if (drop6 !== 1'b0) begin n_errors++; $display("FAIL d6_wr_ok got %0b exp 0", drop6); end
    wr6 = 0; rp6 = 3'd7; rq6 = 3'd6;
    step;
    n_checks++;
    if ({dp6_v, dp6, dq6_v, dq6} !== 34'd0) begin
      n_errors++;
      $display("FAIL d6_oob_read got P=%0b/%0h Q=%0b/%0h exp 0/0", dp6_v, dp6, dq6_v, dq6);
    end
    rp6 = 3'd5; rq6 = 3'd0;
    step;
    n_checks++;
    if ({dp6_v, dp6, dq6_v, dq6} !== {1'b1, 16'hBEEF, 1'b0, 16'h0}) begin
      n_errors++;
      $display("FAIL d6_beef got P=%0b/%0h Q=%0b/%0h exp 1/beef 0/0", dp6_v, dp6, dq6_v, dq6);
    end
    for (int i = 0; i < 150; i++) begin
      wr6 = 1'($urandom);
      wa6 = 3'($urandom);
      ld6 = 16'($urandom);
      rp6 = 3'($urandom);
      rq6 = 3'($urandom);
      ok = wr6 && (wa6 < 3'd6);
      edrop = wr6 && !ok;
      ep = '0; evp = 1'b0; eq = '0; evq = 1'b0;
      if (rp6 < 3'd6) begin
        ep = m6[rp6]; evp = v6[rp6];
        if (ok && wa6 == rp6) begin ep = ld6; evp = 1'b1; end
      end
      if (rq6 < 3'd6) begin
        eq = m6[rq6]; evq = v6[rq6];
        if (ok && wa6 == rq6) begin eq = ld6; evq = 1'b1; end
      end
      if (ok) begin m6[wa6] = ld6; v6[wa6] = 1'b1; end
      step;
      n_checks++;
      if ({dp6_v, dp6, dq6_v, dq6, drop6} !== {evp, ep, evq, eq, edrop}) begin
        n_errors++;
        $display("FAIL rand6 it %0d got P=%0b/%0h Q=%0b/%0h d=%0b exp P=%0b/%0h Q=%0b/%0h d=%0b",
                 i, dp6_v, dp6, dq6_v, dq6, drop6, evp, ep, evq, eq, edrop);
      end
    end
    wr6 = 0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_first();
    test_random8();
    test_clear();
    test_collision();
    test_reset_mid_sweep();
    test_depth6();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
